// File: rtl/xillyusb_loopback_pkg.sv
// Shared types and default widths for the XillyUSB 32-bit loopback endpoint.
package xillyusb_loopback_pkg;

    localparam int LB_DATA_W = 32;
    localparam int LB_ADDR_W = 9;

    // Stream state as seen from the host's file handles.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        EOF    = 2'd3
    } lb_state_t;

endpackage

// File: rtl/xillyusb_sync_fifo.sv
// Single-clock FIFO: dual-port RAM, wrapping pointers, non-wrapping count,
// registered read data that holds between pops, synchronous flush.
module xillyusb_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count
);

    localparam int            DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_push;
    logic              w_pop;

    // Flags come straight from the registered count, so no input reaches an output.
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_rd_data;

    // A flush overrides any push or pop in the same cycle.
    assign w_push = i_wr_en && !o_full  && !i_flush;
    assign w_pop  = i_rd_en && !o_empty && !i_flush;

    // Count update; push and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // RAM write port; storage itself is not reset.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wr_data;
    end

    // Pointers, count and read register. No bypass: a word written this
    // cycle is only visible to the read port from the next cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push)
                r_wptr <= r_wptr + ADDR_W'(1);
            if (w_pop) begin
                r_rptr    <= r_rptr + ADDR_W'(1);
                r_rd_data <= r_mem[r_rptr];
            end
        end
    end

endmodule

// File: rtl/xillyusb_loopback_fifo_32.sv
// XillyUSB 32-bit stream loopback: host writes are queued and served back to
// host reads. Tracks file-open state for end-of-file and flushing.
// Optional feature macro: XILLYUSB_LOOPBACK_EOF_EN (DRAIN/EOF states and eof).
module xillyusb_loopback_fifo_32
    import xillyusb_loopback_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int ADDR_W = LB_ADDR_W
) (
    input  logic              bus_clk,
    input  logic              frontend_rst,
    input  logic              user_w_write_32_wren,
    input  logic [DATA_W-1:0] user_w_write_32_data,
    input  logic              user_w_write_32_open,
    output logic              user_w_write_32_full,
    input  logic              user_r_read_32_rden,
    input  logic              user_r_read_32_open,
    output logic [DATA_W-1:0] user_r_read_32_data,
    output logic              user_r_read_32_empty,
    output logic              user_r_read_32_eof,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow_err,
    output logic              underflow_err
);

    lb_state_t        r_state;
    lb_state_t        w_state_nxt;
    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    logic [ADDR_W:0]  w_count;
    logic             r_overflow;
    logic             r_underflow;

    // Both handles closed means nobody will ever consume what is queued.
    assign w_flush = !user_w_write_32_open && !user_r_read_32_open;

    xillyusb_sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk     (bus_clk),
        .i_rst     (frontend_rst),
        .i_flush   (w_flush),
        .i_wr_en   (user_w_write_32_wren),
        .i_wr_data (user_w_write_32_data),
        .i_rd_en   (user_r_read_32_rden),
        .o_rd_data (user_r_read_32_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign user_w_write_32_full  = w_full;
    assign user_r_read_32_empty  = w_empty;
    assign fill_level            = w_count;
    assign overflow_err          = r_overflow;
    assign underflow_err         = r_underflow;

`ifdef XILLYUSB_LOOPBACK_EOF_EN
    logic w_drain_done;
    logic r_eof;

    // The queue is empty now, or the last word leaves on this edge.
    assign w_drain_done = (w_count == '0) ||
                          ((w_count == (ADDR_W+1)'(1)) && user_r_read_32_rden &&
                           !user_w_write_32_wren);

    // Next-state logic with DRAIN/EOF; flush dominates everything.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (user_w_write_32_open) w_state_nxt = STREAM;
                STREAM: if (!user_w_write_32_open)
                            w_state_nxt = (w_count == '0) ? EOF : DRAIN;
                DRAIN:  if (user_w_write_32_open)  w_state_nxt = STREAM;
                        else if (w_drain_done)     w_state_nxt = EOF;
                EOF:    if (user_w_write_32_open)  w_state_nxt = STREAM;
                        else if (!user_r_read_32_open) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // eof is registered: follows the EOF state one cycle later, gated by empty.
    always_ff @(posedge bus_clk or posedge frontend_rst) begin
        if (frontend_rst)
            r_eof <= 1'b0;
        else
            r_eof <= (r_state == EOF) && w_empty;
    end

    assign user_r_read_32_eof = r_eof;
`else
    // Reduced machine: a writer close simply returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (user_w_write_32_open)  w_state_nxt = STREAM;
                STREAM:  if (!user_w_write_32_open) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign user_r_read_32_eof = 1'b0;
`endif

    // State register.
    always_ff @(posedge bus_clk or posedge frontend_rst) begin
        if (frontend_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Sticky misuse flags; only reset clears them.
    always_ff @(posedge bus_clk or posedge frontend_rst) begin
        if (frontend_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (user_w_write_32_wren && w_full)
                r_overflow <= 1'b1;
            if (user_r_read_32_rden && w_empty)
                r_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xillyusb_loopback_fifo_32.sv
// Scoreboard bench for xillyusb_loopback_fifo_32: stimulus queues expected
// read words, a monitor compares them the cycle after each pop.
module tb_xillyusb_loopback_fifo_32;

    logic        bus_clk = 1'b0;
    logic        frontend_rst = 1'b1;
    logic        wren = 1'b0;
    logic [31:0] wdata = '0;
    logic        w_open = 1'b0;
    logic        rden = 1'b0;
    logic        r_open = 1'b0;
    wire         full;
    wire  [31:0] rdata;
    wire         empty;
    wire         eof;
    wire  [9:0]  fill;
    wire         ovf;
    wire         unf;

`ifdef XILLYUSB_LOOPBACK_EOF_EN
    localparam logic EOF_ON = 1'b1;
`else
    localparam logic EOF_ON = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    logic        exp_pop = 1'b0;
    logic [31:0] last_data = '0;

    xillyusb_loopback_fifo_32 dut (
        .bus_clk              (bus_clk),
        .frontend_rst         (frontend_rst),
        .user_w_write_32_wren (wren),
        .user_w_write_32_data (wdata),
        .user_w_write_32_open (w_open),
        .user_w_write_32_full (full),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_open  (r_open),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_empty (empty),
        .user_r_read_32_eof   (eof),
        .fill_level           (fill),
        .overflow_err         (ovf),
        .underflow_err        (unf)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop issued at an edge must show its word just after that edge.
    always @(posedge bus_clk) begin
        logic        cap;
        logic [31:0] e;
        cap = exp_pop;
        #1;
        if (cap) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rdata: got %0h want <none queued>", rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", rdata, e);
                last_data = e;
            end
        end
    end

    task automatic cyc();
        @(posedge bus_clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] v);
        wren = 1'b1; wdata = v;
        model_q.push_back(v);
        cyc();
        wren = 1'b0;
    endtask

    task automatic pop_word();
        rden = 1'b1; exp_pop = 1'b1;
        exp_q.push_back(model_q.pop_front());
        cyc();
        rden = 1'b0; exp_pop = 1'b0;
    endtask

    task automatic push_pop(input logic [31:0] v);
        wren = 1'b1; wdata = v; rden = 1'b1; exp_pop = 1'b1;
        exp_q.push_back(model_q.pop_front());
        model_q.push_back(v);
        cyc();
        wren = 1'b0; rden = 1'b0; exp_pop = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #3;
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_eof", 32'(eof), 0);
        chk("rst_data", rdata, 0);
        chk("rst_fill", 32'(fill), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        #9;
        frontend_rst = 1'b0;
        w_open = 1'b1; r_open = 1'b1;
        cyc();

        // Reset mid-stream: 10 words left queued, data nonzero.
        for (int i = 0; i < 11; i++) push_word(32'hA0 + 32'(i));
        pop_word();
        cyc();
        chk("mid_fill", 32'(fill), 10);
        frontend_rst = 1'b1;
        #1;
        chk("mr_fill", 32'(fill), 0);
        chk("mr_empty", 32'(empty), 1);
        chk("mr_full", 32'(full), 0);
        chk("mr_data", rdata, 0);
        chk("mr_eof", 32'(eof), 0);
        #1;
        frontend_rst = 1'b0;
        model_q.delete();
        last_data = '0;
        cyc();

        // Fill to 512 back-to-back, then one dropped write.
        for (int i = 0; i < 512; i++) push_word(32'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_lvl", 32'(fill), 512);
        chk("fill_ovf0", 32'(ovf), 0);
        wren = 1'b1; wdata = 32'hDEAD;
        cyc();
        wren = 1'b0;
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_lvl", 32'(fill), 512);
        for (int i = 0; i < 512; i++) begin
            pop_word();
            if (i == 0) chk("full_fall", 32'(full), 0);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_lvl", 32'(fill), 0);

        // Simultaneous push/pop at level 5.
        for (int i = 0; i < 5; i++) push_word(32'h1000 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            push_pop(32'h2000 + 32'(i));
            chk("pp_lvl", 32'(fill), 5);
        end
        for (int i = 0; i < 5; i++) pop_word();
        chk("pp_empty", 32'(empty), 1);

        // Underflow: data holds the last popped word.
        cyc();
        chk("unf_clear", 32'(unf), 0);
        rden = 1'b1;
        cyc();
        rden = 1'b0;
        chk("unf_set", 32'(unf), 1);
        chk("unf_data", rdata, 32'h2013);
        chk("unf_lvl", 32'(fill), 0);

        // Flush with 7 queued.
        for (int i = 0; i < 7; i++) push_word(32'h700 + 32'(i));
        chk("fl_pre", 32'(fill), 7);
        w_open = 1'b0; r_open = 1'b0;
        cyc();
        chk("fl_lvl", 32'(fill), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_data", rdata, 32'h2013);
        chk("fl_eof", 32'(eof), 0);
        model_q.delete();
        w_open = 1'b1; r_open = 1'b1;
        cyc();

        // Writer close after 3 words: eof only once drained.
        for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i));
        w_open = 1'b0;
        cyc();
        chk("eof_q3", 32'(eof), 0);
        pop_word();
        chk("eof_p1", 32'(eof), 0);
        pop_word();
        chk("eof_p2", 32'(eof), 0);
        pop_word();
        chk("eof_p3", 32'(eof), 0);
        chk("eof_empty", 32'(empty), 1);
        cyc();
        chk("eof_set", 32'(eof), 32'(EOF_ON));
        cyc();
        chk("eof_hold", 32'(eof), 32'(EOF_ON));
        w_open = 1'b1;
        cyc();
        cyc();
        chk("eof_reopen", 32'(eof), 0);

        cyc();
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xillyusb_loopback_fifo_32.md
# xillyusb_loopback_fifo_32

User-side endpoint for the XillyUSB 32-bit stream pipes: it answers the core's host-to-FPGA write strobes (`user_w_write_32_*`) and serves the core's FPGA-to-host read strobes (`user_r_read_32_*`) from one synchronous FIFO, forming a data loopback. It tracks writer/reader file-open state to propagate end-of-file and to flush stale data. It sits in the `bus_clk` domain beside `xillyusb_core`, which drives its strobes.

## Interface
Parameters:
- `DATA_W`, 32, stream word width (fixed by the core pipe).
- `ADDR_W`, 9, FIFO address width; depth = 2^ADDR_W = 512 words.

Ports:
- `bus_clk` in 1: the single clock; all logic is on its rising edge.
- `frontend_rst` in 1: asynchronous, active-high reset.
- `user_w_write_32_wren` in 1: core write strobe.
- `user_w_write_32_data` in DATA_W: write word, valid with wren.
- `user_w_write_32_open` in 1: host write file open.
- `user_w_write_32_full` out 1: FIFO full; the core must not strobe wren.
- `user_r_read_32_rden` in 1: core read strobe.
- `user_r_read_32_open` in 1: host read file open.
- `user_r_read_32_data` out DATA_W: read word, valid the cycle after rden.
- `user_r_read_32_empty` out 1: FIFO empty.
- `user_r_read_32_eof` out 1: end-of-file to the host.
- `fill_level` out ADDR_W+1: current word count, range 0..2^ADDR_W.
- `overflow_err` out 1: sticky; set when wren arrives while full.
- `underflow_err` out 1: sticky; set when rden arrives while empty.

## Operation
- **Push:** occurs when `wren && !full`. A wren while full drops the word and sets `overflow_err`.
- **Pop:** occurs when `rden && !empty`. The popped word appears on `user_r_read_32_data` the next cycle and holds until the next pop. A rden while empty leaves data unchanged and sets `underflow_err`.
- **Simultaneous push and pop:** both execute and the count is unchanged. There is no bypass: a push into an empty FIFO is not poppable in the same cycle.
- **Status flags:** `full` = (count == 2^ADDR_W) and `empty` = (count == 0), both decoded from the registered count. Pointers wrap modulo 2^ADDR_W. The count is ADDR_W+1 bits and never wraps.
- **Stream state machine:**
  - IDLE: writer is closed and the FIFO is empty. Goes to STREAM on `user_w_write_32_open` = 1.
  - STREAM: goes to DRAIN when the writer closes with count > 0. Goes to EOF when the writer closes with count = 0.
  - DRAIN: goes to EOF when count reaches 0. Goes to STREAM if the writer reopens.
  - EOF: `eof` = 1 while `empty` = 1. Goes to STREAM if the writer reopens. Goes to IDLE when the reader closes.
- **Flush:** when `user_r_read_32_open` and `user_w_write_32_open` are both 0, the pointers and count clear on the next edge, the state goes to IDLE, and data output is held. If that same cycle also has a push or pop, the flush wins.
- **Error flags:** cleared only by `frontend_rst`.

## Timing
- **Reset values:** full = 0, empty = 1, eof = 0, data = 0, fill_level = 0, both error flags = 0, state = IDLE.
- **Push at edge N:** empty falls and fill_level increments after edge N. The word is poppable by a rden in cycle N+1.
- **Pop at edge N:** data is valid after edge N, and full falls after edge N.
- **eof:** a registered output. It asserts one cycle after the EOF state is entered.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- `XILLYUSB_LOOPBACK_EOF_EN` defined:
  - DRAIN and EOF states are built as described above.
- `XILLYUSB_LOOPBACK_EOF_EN` undefined:
  - `user_r_read_32_eof` is tied to 0.
  - The state machine reduces to IDLE/STREAM; a writer close returns to IDLE with no eof.
  - Flush behaviour is unchanged.

## Structure
- **Package `xillyusb_loopback_pkg`:**
  - State enum `lb_state_t` (IDLE, STREAM, DRAIN, EOF).
  - Default-width constants `LB_DATA_W` = 32 and `LB_ADDR_W` = 9.
- **Sub-module `xillyusb_sync_fifo`:**
  - Parameterised dual-port RAM, pointers, count, full/empty and registered read data, with a synchronous `flush` input.
  - The top level holds the state machine, eof generation and error flags.

## Test plan
- **Reset mid-stream:** assert `frontend_rst` with 10 words queued. All outputs return to reset values immediately, without waiting for an edge.
- **Fill and drain:** write 512 words 0..511 back-to-back.
  - full = 1 after the 512th push.
  - A 513th wren sets `overflow_err` and is dropped.
  - Reading 512 words yields 0..511 in order, and empty = 1 after the last pop.
- **Simultaneous push and pop:** at fill_level 5, apply wren and rden together for 20 cycles. fill_level stays 5 and data order is preserved.
- **Underflow:** rden on an empty FIFO sets `underflow_err`, and data keeps its last value.
- **EOF (EOF_EN defined):**
  - Write 3 words, then drop writer open. eof stays 0 until the 3rd pop, then eof = 1 one cycle after empty.
  - Reopening the writer clears eof.
- **Flush:** with 7 words queued, drop both opens. fill_level = 0 and empty = 1 after one edge, and the state is IDLE.
